digdug_devbus_arbiter: RTL and testbench
========================================

// Module: digdug_devbus_arbiter
// PURPOSE
//  Shares the common I/O device bus (DEV_AD/RD/WR/DI/DO/DV) between the three CPU cores.
//  Runs one transaction at a time with round-robin grant; requesters held in reset are masked.
//  Sits between the CPU cores and the I/O device block, in the MCLK (48 MHz) domain.
//  Returns read data and a single-cycle acknowledge; a read timeout guards against a device that never answers.
// PARAMETERS
//  NREQ      3      number of requesters (CPU0 main, CPU1 sub, CPU2 sound)
//  TIMEOUT   15     WAIT cycles before a read is aborted; 4-bit counter, legal range 1..15
//  IDLE_DATA 8'hFF  read data returned on timeout (open-bus value)
// PORTS
//  MCLK    in   1        clock, 48.0 MHz
//  RESET   in   1        asynchronous, active-high reset
//  RSTS    in   NREQ     per-requester reset state; 1 = requester masked
//  REQ_RD  in   NREQ     read request, level, held until ACK
//  REQ_WR  in   NREQ     write request, level, held until ACK
//  REQ_AD  in   16*NREQ  request address, packed, requester i = [16i+15:16i]
//  REQ_DI  in   8*NREQ   write data, packed, requester i = [8i+7:8i]
//  REQ_ACK out  NREQ     one-hot, 1-cycle completion pulse
//  REQ_DO  out  8        read data, valid in the ACK cycle, held until the next read completes
//  GRANT   out  NREQ     one-hot owner of the current transaction; 0 when idle
//  DEV_AD  out  16       device address, stable from ISSUE through DONE
//  DEV_RD  out  1        read strobe, 1 cycle, in ISSUE
//  DEV_WR  out  1        write strobe, 1 cycle, in ISSUE
//  DEV_DI  out  8        write data to the device, stable with DEV_AD
//  DEV_DV  in   1        device read data valid
//  DEV_DO  in   8        device read data, captured when DEV_DV=1
// BEHAVIOUR
//  - Reset: every output registered and 0 (REQ_DO=8'h00); state=IDLE; last-grant pointer=NREQ-1, so CPU0 wins first.
//  - pending = (REQ_RD|REQ_WR) & ~RSTS & ~REQ_ACK; a requester still holding its request in its own ACK cycle is not re-granted that cycle.
//  - IDLE: if pending!=0, pick the first set bit after the last grant (wrapping).
//    Latch address, data and operation; set GRANT and the pointer; go to ISSUE.
//  - REQ_RD and REQ_WR both set: treated as a write.
//  - ISSUE: assert DEV_RD or DEV_WR for exactly 1 cycle.
//    Write -> DONE.
//    Read with DEV_DV=1 in this cycle -> capture DEV_DO -> DONE.
//    Read otherwise -> WAIT, timeout counter=0.
//  - WAIT: DEV_DV=1 -> capture DEV_DO -> DONE.
//    Otherwise counter+1; counter==TIMEOUT-1 -> capture IDLE_DATA -> DONE.
//  - DONE: REQ_ACK[g]=1 for 1 cycle, REQ_DO valid -> IDLE. GRANT clears when IDLE is re-entered.
//  - Latency from request seen in IDLE (cycle 0): write ACK at cycle 2.
//    Read ACK at cycle 2 (DV in ISSUE), 3 (DV in first WAIT cycle), max TIMEOUT+2.
//  - RSTS[g] rises in ISSUE or WAIT: abort to IDLE, no ACK, REQ_DO unchanged. An already-issued strobe is not retracted.
//  - RSTS[g] rises in DONE: the ACK is still issued.
//  - DEV_DV outside ISSUE/WAIT is ignored. Requests change only while IDLE is sampling; later changes are ignored until ACK.
//  - RESET mid-transaction: immediate return to reset values; no ACK is owed.
// STRUCTURE
//  - Shared package digdug_bus_pkg: state enum (IDLE, ISSUE, WAIT, DONE), DEV_AW=16, DEV_DW=8, TO_W=4.
//  - Sub-module digdug_rr_pick: combinational round-robin picker.
//    Inputs: pending[NREQ] and the last one-hot grant. Outputs: next one-hot grant and a valid flag.
//  - The FSM, latches and timeout counter live in the top; no other sub-modules.
// TESTING
//  1 Write: CPU0 REQ_WR, AD=16'h6800, DI=8'h5A -> DEV_WR pulse at cycle 1 with AD/DI; REQ_ACK=3'b001 at cycle 2.
//  2 Read: CPU1 REQ_RD, AD=16'h7000; device gives DV with DO=8'hC3 two cycles after the strobe
//    -> ACK=3'b010 with REQ_DO=8'hC3 at cycle 4.
//  3 Fairness: all three hold reads back-to-back, DV immediate -> grant order 0,1,2,0,1,2; no requester starved.
//  4 Timeout: read, DEV_DV held 0 -> ACK at cycle TIMEOUT+2 (=17), REQ_DO=8'hFF.
//  5 Masking: RSTS=3'b010 with all three requesting -> only CPU0/CPU2 granted.
//    RSTS[g] raised in WAIT -> return to IDLE, no ACK.
//  6 RESET asserted during WAIT -> all outputs 0 asynchronously; the next grant after release goes to CPU0.

Source files
------------

// File: rtl/digdug_bus_pkg.sv
// Shared types and widths for the Dig Dug device-bus arbiter.
// Imported by the arbiter top and its round-robin picker.
package digdug_bus_pkg;

  localparam int DEV_AW = 16;
  localparam int DEV_DW = 8;
  localparam int TO_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/digdug_rr_pick.sv
// Combinational round-robin picker: the first pending requester after the
// previous grant (wrapping) wins; valid_o flags that anything was pending.
module digdug_rr_pick #(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0] pending_i,
  input  logic [NREQ-1:0] lastGrant_i,
  output logic [NREQ-1:0] grant_o,
  output logic            valid_o
);

  always_comb begin
    int lastIdx;
    int idx;
    logic found;
    lastIdx = 0;
    idx     = 0;
    found   = 1'b0;
    grant_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (lastGrant_i[i]) lastIdx = i;
    end
    // Search starts one past the previous owner so it is served last.
    for (int off = 1; off <= NREQ; off++) begin
      idx = (lastIdx + off) % NREQ;
      if (!found && pending_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/digdug_devbus_arbiter.sv
// Round-robin arbiter sharing the I/O device bus between the three CPU cores,
// one transaction at a time, with a read timeout returning open-bus data.
module digdug_devbus_arbiter
  import digdug_bus_pkg::*;
#(
  parameter int                NREQ      = 3,
  parameter int                TIMEOUT   = 15,
  parameter logic [DEV_DW-1:0] IDLE_DATA = 8'hFF
) (
  input  logic                     MCLK,
  input  logic                     RESET,
  input  logic [NREQ-1:0]          RSTS,
  input  logic [NREQ-1:0]          REQ_RD,
  input  logic [NREQ-1:0]          REQ_WR,
  input  logic [DEV_AW*NREQ-1:0]   REQ_AD,
  input  logic [DEV_DW*NREQ-1:0]   REQ_DI,
  output logic [NREQ-1:0]          REQ_ACK,
  output logic [DEV_DW-1:0]        REQ_DO,
  output logic [NREQ-1:0]          GRANT,
  output logic [DEV_AW-1:0]        DEV_AD,
  output logic                     DEV_RD,
  output logic                     DEV_WR,
  output logic [DEV_DW-1:0]        DEV_DI,
  input  logic                     DEV_DV,
  input  logic [DEV_DW-1:0]        DEV_DO
);

  localparam logic [NREQ-1:0] LAST_RST = {1'b1, {(NREQ-1){1'b0}}};
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   last_q, last_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              isWr_q, isWr_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [DEV_AW-1:0] ad_q, ad_d;
  logic [DEV_DW-1:0] di_q, di_d;
  logic [DEV_DW-1:0] do_q, do_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;

  logic [NREQ-1:0]   pending;
  logic [NREQ-1:0]   pick;
  logic              pickValid;
  logic [DEV_AW-1:0] selAd;
  logic [DEV_DW-1:0] selDi;
  logic              ownerMasked;

  // A requester still holding its level in its own ACK cycle must not win again.
  assign pending     = (REQ_RD | REQ_WR) & ~RSTS & ~ack_q;
  assign ownerMasked = |(RSTS & grant_q);

  digdug_rr_pick #(.NREQ(NREQ)) u_pick (
    .pending_i   (pending),
    .lastGrant_i (last_q),
    .grant_o     (pick),
    .valid_o     (pickValid)
  );

  always_comb begin
    selAd = '0;
    selDi = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick[i]) begin
        selAd = REQ_AD[DEV_AW*i +: DEV_AW];
        selDi = REQ_DI[DEV_DW*i +: DEV_DW];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    ack_d   = '0;
    isWr_d  = isWr_q;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    ad_d    = ad_q;
    di_d    = di_q;
    do_d    = do_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (pickValid) begin
          grant_d = pick;
          last_d  = pick;
          ad_d    = selAd;
          di_d    = selDi;
          // A simultaneous read and write request is served as a write.
          isWr_d  = |(pick & REQ_WR);
          wr_d    = |(pick & REQ_WR);
          rd_d    = ~(|(pick & REQ_WR));
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (ownerMasked) begin
          grant_d = '0;
          state_d = IDLE;
        end else if (isWr_q) begin
          ack_d   = grant_q;
          state_d = DONE;
        end else if (DEV_DV) begin
          do_d    = DEV_DO;
          ack_d   = grant_q;
          state_d = DONE;
        end else begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (ownerMasked) begin
          grant_d = '0;
          state_d = IDLE;
        end else if (DEV_DV) begin
          do_d    = DEV_DO;
          ack_d   = grant_q;
          state_d = DONE;
        end else if (cnt_q == TO_LAST) begin
          do_d    = IDLE_DATA;
          ack_d   = grant_q;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      DONE: begin
        grant_d = '0;
        state_d = IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LAST_RST;
      ack_q   <= '0;
      isWr_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ad_q    <= '0;
      di_q    <= '0;
      do_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      ack_q   <= ack_d;
      isWr_q  <= isWr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      ad_q    <= ad_d;
      di_q    <= di_d;
      do_q    <= do_d;
      cnt_q   <= cnt_d;
    end
  end

  assign REQ_ACK = ack_q;
  assign REQ_DO  = do_q;
  assign GRANT   = grant_q;
  assign DEV_AD  = ad_q;
  assign DEV_RD  = rd_q;
  assign DEV_WR  = wr_q;
  assign DEV_DI  = di_q;

endmodule

// File: tb/tb_digdug_devbus_arbiter.sv
// Directed self-checking bench for the device-bus arbiter: write, delayed read,
// fairness, timeout, masking/abort and asynchronous reset.
module tb_digdug_devbus_arbiter;

  logic        MCLK;
  logic        RESET;
  logic [2:0]  RSTS;
  logic [2:0]  REQ_RD;
  logic [2:0]  REQ_WR;
  logic [47:0] REQ_AD;
  logic [23:0] REQ_DI;
  logic [2:0]  REQ_ACK;
  logic [7:0]  REQ_DO;
  logic [2:0]  GRANT;
  logic [15:0] DEV_AD;
  logic        DEV_RD;
  logic        DEV_WR;
  logic [7:0]  DEV_DI;
  logic        DEV_DV;
  logic [7:0]  DEV_DO;

  int total = 0;
  int bad   = 0;

  digdug_devbus_arbiter dut (
    .MCLK    (MCLK),
    .RESET   (RESET),
    .RSTS    (RSTS),
    .REQ_RD  (REQ_RD),
    .REQ_WR  (REQ_WR),
    .REQ_AD  (REQ_AD),
    .REQ_DI  (REQ_DI),
    .REQ_ACK (REQ_ACK),
    .REQ_DO  (REQ_DO),
    .GRANT   (GRANT),
    .DEV_AD  (DEV_AD),
    .DEV_RD  (DEV_RD),
    .DEV_WR  (DEV_WR),
    .DEV_DI  (DEV_DI),
    .DEV_DV  (DEV_DV),
    .DEV_DO  (DEV_DO)
  );

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, want %h", tag, actual, expected);
    end
  endtask

  // Outputs are sampled 1 ns after the rising edge, inputs change there too.
  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] rd, input logic [2:0] wr, input logic [2:0] rsts);
    REQ_RD = rd;
    REQ_WR = wr;
    RSTS   = rsts;
  endtask

  task automatic waitAck(input string tag, input logic [2:0] expAck, output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (REQ_ACK == 3'b000 && cycles < 40);
    checkOutput(tag, REQ_ACK, expAck);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ack"}, REQ_ACK, 3'b000);
    checkOutput({tag, "_do"}, REQ_DO, 8'h00);
    checkOutput({tag, "_gnt"}, GRANT, 3'b000);
    checkOutput({tag, "_bus"}, {DEV_AD, DEV_DI, 6'b0, DEV_RD, DEV_WR}, 32'h0);
  endtask

  initial begin
    int n;
    logic [2:0] order [6];
    logic [2:0] maskOrder [4];
    order     = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    maskOrder = '{3'b100, 3'b001, 3'b100, 3'b001};

    RESET  = 1'b1;
    DEV_DV = 1'b0;
    DEV_DO = 8'h00;
    REQ_AD = '0;
    REQ_DI = '0;
    applyStimulus(3'b000, 3'b000, 3'b000);
    tick();
    tick();
    checkAllZero("reset");
    RESET = 1'b0;
    tick();

    // Write from CPU0
    REQ_AD[15:0] = 16'h6800;
    REQ_DI[7:0]  = 8'h5A;
    applyStimulus(3'b000, 3'b001, 3'b000);
    tick();
    checkOutput("wr_strobe", {DEV_WR, DEV_RD}, 2'b10);
    checkOutput("wr_ad", DEV_AD, 16'h6800);
    checkOutput("wr_di", DEV_DI, 8'h5A);
    checkOutput("wr_gnt", GRANT, 3'b001);
    checkOutput("wr_ack_early", REQ_ACK, 3'b000);
    tick();
    checkOutput("wr_ack", REQ_ACK, 3'b001);
    checkOutput("wr_strobe_off", DEV_WR, 1'b0);
    applyStimulus(3'b000, 3'b000, 3'b000);
    tick();
    checkOutput("wr_ack_pulse", REQ_ACK, 3'b000);
    checkOutput("wr_gnt_clear", GRANT, 3'b000);

    // Read from CPU1 with data two cycles after the strobe
    REQ_AD[31:16] = 16'h7000;
    applyStimulus(3'b010, 3'b000, 3'b000);
    tick();
    checkOutput("rd_strobe", {DEV_WR, DEV_RD}, 2'b01);
    checkOutput("rd_ad", DEV_AD, 16'h7000);
    checkOutput("rd_gnt", GRANT, 3'b010);
    tick();
    checkOutput("rd_strobe_off", DEV_RD, 1'b0);
    checkOutput("rd_wait_ack", REQ_ACK, 3'b000);
    tick();
    DEV_DV = 1'b1;
    DEV_DO = 8'hC3;
    checkOutput("rd_wait2_ack", REQ_ACK, 3'b000);
    tick();
    checkOutput("rd_ack", REQ_ACK, 3'b010);
    checkOutput("rd_do", REQ_DO, 8'hC3);
    DEV_DV = 1'b0;
    applyStimulus(3'b000, 3'b000, 3'b000);
    tick();

    // Fairness after reset: all three hold reads, device answers immediately
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    DEV_DV = 1'b1;
    DEV_DO = 8'hA5;
    applyStimulus(3'b111, 3'b000, 3'b000);
    for (int k = 0; k < 6; k++) begin
      waitAck($sformatf("rr_ack%0d", k), order[k], n);
      checkOutput($sformatf("rr_gnt%0d", k), GRANT, order[k]);
      checkOutput($sformatf("rr_lat%0d", k), n, (k == 0) ? 2 : 3);
    end
    checkOutput("rr_do", REQ_DO, 8'hA5);
    applyStimulus(3'b000, 3'b000, 3'b000);
    DEV_DV = 1'b0;
    tick();

    // Timeout: CPU0 read, device never answers
    applyStimulus(3'b001, 3'b000, 3'b000);
    waitAck("to_ack", 3'b001, n);
    checkOutput("to_lat", n, 17);
    checkOutput("to_do", REQ_DO, 8'hFF);
    applyStimulus(3'b000, 3'b000, 3'b000);
    tick();

    // CPU1 masked while everyone requests; last owner was CPU0
    DEV_DV = 1'b1;
    DEV_DO = 8'h3C;
    applyStimulus(3'b111, 3'b000, 3'b010);
    for (int k = 0; k < 4; k++) begin
      waitAck($sformatf("mask_ack%0d", k), maskOrder[k], n);
    end
    checkOutput("mask_do", REQ_DO, 8'h3C);
    applyStimulus(3'b000, 3'b000, 3'b000);
    DEV_DV = 1'b0;
    tick();

    // CPU1 read aborted by its reset rising in WAIT
    applyStimulus(3'b010, 3'b000, 3'b000);
    tick();
    checkOutput("abort_gnt", GRANT, 3'b010);
    tick();
    applyStimulus(3'b010, 3'b000, 3'b010);
    tick();
    checkOutput("abort_gnt_clear", GRANT, 3'b000);
    checkOutput("abort_ack", REQ_ACK, 3'b000);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (REQ_ACK != 3'b000) n++;
    end
    checkOutput("abort_no_ack", n, 0);
    checkOutput("abort_do_kept", REQ_DO, 8'h3C);
    applyStimulus(3'b000, 3'b000, 3'b000);
    tick();

    // Asynchronous reset while CPU2 read is waiting
    applyStimulus(3'b100, 3'b000, 3'b000);
    tick();
    tick();
    checkOutput("rst_pre_gnt", GRANT, 3'b100);
    #2;
    RESET = 1'b1;
    #1;
    checkAllZero("async_rst");
    applyStimulus(3'b000, 3'b000, 3'b000);
    tick();
    RESET = 1'b0;
    DEV_DV = 1'b1;
    applyStimulus(3'b111, 3'b000, 3'b000);
    waitAck("post_rst_ack", 3'b001, n);
    applyStimulus(3'b000, 3'b000, 3'b000);
    DEV_DV = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] simulation watchdog expired");
  end

endmodule
